// File: rtl/keypad_matrix_scanner_if.sv
// Signal bundle between the keypad scanner and the board: matrix rows and columns
// plus the debounced key event outputs consumed by the counter/display logic.
interface keypad_matrix_scanner_if;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  ROW,
        output COL,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output ROW,
        input  COL,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: drives one column low at a time, decodes a whole
// frame of row samples and debounces the result into single press strobes.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_FRAMES = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    keypad_matrix_scanner_if.master kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEB_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_FRAMES);

    logic [3:0]       rowMeta_q, rowS_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       frameLow_q, frameLow_d;
    logic [3:0]       frameCode_q, frameCode_d;
    logic             candKey_q, candKey_d;
    logic [3:0]       candCode_q, candCode_d;
    logic [CNT_W-1:0] stable_q, stable_d;
    logic             frameDone_q, frameDone_d;
    logic [3:0]       keyCode_q, keyCode_d;
    logic             keyValid_q, keyValid_d;
    logic             keyHeld_q, keyHeld_d;

    logic             sampleEn, frameEnd, resKey, sameResult, stableFull;
    logic [3:0]       colLow, newCode;
    logic [2:0]       colCnt, lowTotal;
    logic [1:0]       colRow, newLow;

    always_comb begin
        sampleEn   = (div_q == DIV_LAST);
        frameEnd   = sampleEn && (col_q == 2'd3);
        colLow     = ~rowS_q;
        colCnt     = 3'(colLow[0]) + 3'(colLow[1]) + 3'(colLow[2]) + 3'(colLow[3]);
        colRow     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (colLow[i]) colRow = 2'(i);
        end
        // Low-bit tally saturates at 2: anything beyond one key is rejected as ghosting.
        lowTotal   = {1'b0, frameLow_q} + colCnt;
        newLow     = (lowTotal >= 3'd2) ? 2'd2 : lowTotal[1:0];
        newCode    = (frameLow_q == 2'd0) ? {colRow, col_q} : frameCode_q;
        resKey     = (newLow == 2'd1);
        sameResult = (resKey == candKey_q) && (!resKey || (newCode == candCode_q));
        stableFull = (stable_q == DEB_MAX);

        div_d       = sampleEn ? '0 : div_q + 1'b1;
        col_d       = sampleEn ? col_q + 2'd1 : col_q;
        frameLow_d  = frameLow_q;
        frameCode_d = frameCode_q;
        if (sampleEn) begin
            frameLow_d  = frameEnd ? 2'd0 : newLow;
            frameCode_d = frameEnd ? 4'd0 : newCode;
        end

        candKey_d   = candKey_q;
        candCode_d  = candCode_q;
        stable_d    = stable_q;
        frameDone_d = frameEnd;
        if (frameEnd) begin
            if (sameResult) begin
                stable_d = stableFull ? stable_q : stable_q + 1'b1;
            end else begin
                candKey_d  = resKey;
                candCode_d = resKey ? newCode : 4'd0;
                stable_d   = CNT_W'(1);
            end
        end

        // Decisions are taken one clock after the frame closes, on the updated count.
        keyCode_d  = keyCode_q;
        keyValid_d = 1'b0;
        keyHeld_d  = keyHeld_q;
        if (frameDone_q && stableFull) begin
            if (candKey_q && !keyHeld_q) begin
                keyCode_d  = candCode_q;
                keyValid_d = 1'b1;
                keyHeld_d  = 1'b1;
            end else if (!candKey_q && keyHeld_q) begin
                keyHeld_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rowMeta_q   <= 4'b1111;
            rowS_q      <= 4'b1111;
            div_q       <= '0;
            col_q       <= 2'd0;
            frameLow_q  <= 2'd0;
            frameCode_q <= 4'd0;
            candKey_q   <= 1'b0;
            candCode_q  <= 4'd0;
            stable_q    <= '0;
            frameDone_q <= 1'b0;
            keyCode_q   <= 4'd0;
            keyValid_q  <= 1'b0;
            keyHeld_q   <= 1'b0;
        end else begin
            rowMeta_q   <= kp.ROW;
            rowS_q      <= rowMeta_q;
            div_q       <= div_d;
            col_q       <= col_d;
            frameLow_q  <= frameLow_d;
            frameCode_q <= frameCode_d;
            candKey_q   <= candKey_d;
            candCode_q  <= candCode_d;
            stable_q    <= stable_d;
            frameDone_q <= frameDone_d;
            keyCode_q   <= keyCode_d;
            keyValid_q  <= keyValid_d;
            keyHeld_q   <= keyHeld_d;
        end
    end

    assign kp.COL       = ~(4'b0001 << col_q);
    assign kp.key_code  = keyCode_q;
    assign kp.key_valid = keyValid_q;
    assign kp.key_held  = keyHeld_q;
endmodule
